// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the matrix arbiters.
//   arb_state_e : controller state (idle / burst locked)
//   onehot2bin  : one-hot (up to 32 bits) to binary index, 0 for all-zero
//   tri_idx     : position of matrix bit M[i][j] (i<j) in the flattened
//                 upper triangle, row-major
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // ORing the indices of set bits is exact for a one-hot input and costs
    // no priority chain.
    function automatic int unsigned onehot2bin(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (((oh >> i) & 32'd1) != 32'd0) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

    function automatic int tri_idx(input int i, input int j, input int width);
        return i * width - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/arb_matrix_pick.sv
// ---------------------------------------------------------------------------
// arb_matrix_pick
// Purely combinational matrix-arbiter pick. A requester wins when it is
// valid and beats every other valid requester.
//   req_vld_i : per-requester request
//   m_tri_i   : upper triangle of the priority matrix, bit tri_idx(i,j)
//               set means i beats j (j beats i is its complement)
//   win_o     : one-hot winner, zero when nobody requests
// ---------------------------------------------------------------------------
module arb_matrix_pick
    import arb_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int NPAIR = WIDTH * (WIDTH - 1) / 2
) (
    input  logic [WIDTH-1:0] req_vld_i,
    input  logic [NPAIR-1:0] m_tri_i,
    output logic [WIDTH-1:0] win_o
);

    // Full matrix rebuilt from the triangle; row i, bit j = "i beats j".
    logic [WIDTH*WIDTH-1:0] beats;

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            if (i < j) begin : g_upper
                assign beats[i*WIDTH+j] = m_tri_i[tri_idx(i, j, WIDTH)];
            end else if (i > j) begin : g_lower
                assign beats[i*WIDTH+j] = ~m_tri_i[tri_idx(j, i, WIDTH)];
            end else begin : g_diag
                // Self-comparison never blocks.
                assign beats[i*WIDTH+j] = 1'b1;
            end
        end
        assign win_o[i] = req_vld_i[i] & (&(~req_vld_i | beats[i*WIDTH +: WIDTH]));
    end

endmodule

// File: rtl/arb_matrix_lru_ctrl.sv
// ---------------------------------------------------------------------------
// arb_matrix_lru_ctrl
// Least-recently-granted matrix arbiter with burst locking and a burst-length
// watchdog, in front of one valid/ready channel. WIDTH must be 2..32.
//   clk, rst_n  : clock, synchronous active-low reset
//   req_vld     : per-requester beat valid
//   req_last    : per-requester last-beat flag (qualified by req_vld)
//   out_rdy     : downstream ready
//   out_vld     : downstream valid (= |gnt, never depends on out_rdy)
//   out_last    : req_last of the granted requester
//   gnt/gnt_idx : one-hot grant and its binary index (0 when no grant)
//   locked      : burst in progress, owner fixed
//   burst_trunc : one-cycle pulse after a burst hit MAX_BURST beats
// ---------------------------------------------------------------------------
module arb_matrix_lru_ctrl
    import arb_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int MAX_BURST = 16,
    localparam int IDX_W     = $clog2(WIDTH),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_vld,
    input  logic [WIDTH-1:0] req_last,
    input  logic             out_rdy,
    output logic             out_vld,
    output logic             out_last,
    output logic [WIDTH-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             locked,
    output logic             burst_trunc
);

    localparam int               NPAIR    = WIDTH * (WIDTH - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [NPAIR-1:0] m_q,     m_d;
    logic             trunc_q, trunc_d;

    logic [NPAIR-1:0] m_upd;
    logic [WIDTH-1:0] win;
    logic [WIDTH-1:0] gnt_raw;
    logic [IDX_W-1:0] idx_raw;
    logic             last_raw;
    logic             fire;

    arb_matrix_pick #(.WIDTH(WIDTH)) u_pick (
        .req_vld_i (req_vld),
        .m_tri_i   (m_q),
        .win_o     (win)
    );

    // Demote the current grantee: it loses to everyone, all other pairs keep
    // their relative order.
    for (genvar i = 0; i < WIDTH; i++) begin : g_upd_row
        for (genvar j = i + 1; j < WIDTH; j++) begin : g_upd_col
            localparam int K = tri_idx(i, j, WIDTH);
            assign m_upd[K] = (idx_raw == IDX_W'(i)) ? 1'b0 :
                              (idx_raw == IDX_W'(j)) ? 1'b1 : m_q[K];
        end
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    // The matrix is a handful of flops, not a RAM, so it is reset along with
    // the FSM to give a defined priority order out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            m_q     <= '1;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            trunc_q <= trunc_d;
        end
    end

    // Next-state logic
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        trunc_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (fire) begin
                    if (last_raw || (MAX_BURST == 1)) begin
                        // A non-last single beat can only reach here when
                        // bursts are capped at one beat: that is a truncation.
                        m_d     = m_upd;
                        trunc_d = ~last_raw;
                    end else begin
                        state_d = ARB_LOCK;
                        owner_d = idx_raw;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ARB_LOCK: begin
                if (fire) begin
                    if (last_raw) begin
                        state_d = ARB_IDLE;
                        m_d     = m_upd;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ARB_IDLE;
                        m_d     = m_upd;
                        trunc_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output logic; all outputs are held low while reset is asserted.
    always_comb begin
        if (state_q == ARB_LOCK) begin
            // Owner keeps the channel; a dropped request stalls, never reassigns.
            gnt_raw = (WIDTH'(1) << owner_q) & req_vld;
        end else begin
            gnt_raw = win;
        end
        idx_raw  = IDX_W'(onehot2bin(32'(gnt_raw)));
        last_raw = |(gnt_raw & req_last);
        fire     = (|gnt_raw) & out_rdy;

        gnt         = rst_n ? gnt_raw : '0;
        gnt_idx     = rst_n ? idx_raw : '0;
        out_vld     = rst_n & (|gnt_raw);
        out_last    = rst_n & last_raw;
        locked      = rst_n & (state_q == ARB_LOCK);
        burst_trunc = rst_n & trunc_q;
    end

endmodule

// File: tb/tb_arb_matrix_lru_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arb_matrix_lru_ctrl
// Directed scenarios for the LRG burst arbiter (WIDTH=4, MAX_BURST=4).
// Expected outputs come from a priority-list model (highest priority first,
// winner moved to the tail on burst completion) and are queued when the
// stimulus is driven, then popped and compared against the DUT.
// ---------------------------------------------------------------------------
module tb_arb_matrix_lru_ctrl;

    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] req_vld = '0;
    logic [WIDTH-1:0] req_last = '0;
    logic             out_rdy = 1'b0;
    logic             out_vld;
    logic             out_last;
    logic [WIDTH-1:0] gnt;
    logic [1:0]       gnt_idx;
    logic             locked;
    logic             burst_trunc;

    // Observation bundle: {gnt, idx, vld, last, locked, trunc}
    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       last;
        logic       locked;
        logic       trunc;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int prio[$];
    bit m_lock;
    int m_owner;
    int m_cnt;
    bit m_trunc;

    arb_matrix_lru_ctrl #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_last    (req_last),
        .out_rdy     (out_rdy),
        .out_vld     (out_vld),
        .out_last    (out_last),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .locked      (locked),
        .burst_trunc (burst_trunc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic void model_reset();
        prio    = {0, 1, 2, 3};
        m_lock  = 1'b0;
        m_owner = 0;
        m_cnt   = 0;
        m_trunc = 1'b0;
    endfunction

    function automatic logic [3:0] model_gnt(input logic [3:0] v);
        if (m_lock) return v & 4'(1 << m_owner);
        foreach (prio[k]) begin
            if ((v & 4'(1 << prio[k])) != 4'b0) return 4'(1 << prio[k]);
        end
        return 4'b0;
    endfunction

    function automatic logic [1:0] model_idx(input logic [3:0] g);
        for (int k = 0; k < 4; k++) begin
            if (g == 4'(1 << k)) return 2'(k);
        end
        return 2'd0;
    endfunction

    function automatic void demote(input int w);
        int pos;
        pos = -1;
        foreach (prio[k]) if (prio[k] == w) pos = k;
        if (pos >= 0) begin
            prio.delete(pos);
            prio.push_back(w);
        end
    endfunction

    function automatic void model_edge(input logic [3:0] v, input logic [3:0] l, input logic r);
        logic [3:0] g;
        bit         fire_m;
        bit         lst;
        bit         nxt_trunc;
        int         w;
        g         = model_gnt(v);
        fire_m    = (g != 4'b0) && r;
        lst       = |(g & l);
        w         = int'(model_idx(g));
        nxt_trunc = 1'b0;
        if (fire_m) begin
            if (!m_lock) begin
                if (lst) demote(w);
                else if (MAX_BURST == 1) begin
                    demote(w);
                    nxt_trunc = 1'b1;
                end else begin
                    m_lock  = 1'b1;
                    m_owner = w;
                    m_cnt   = 1;
                end
            end else begin
                if (lst) begin
                    m_lock = 1'b0;
                    demote(w);
                end else if (m_cnt == MAX_BURST - 1) begin
                    m_lock    = 1'b0;
                    nxt_trunc = 1'b1;
                    demote(w);
                end else begin
                    m_cnt++;
                end
            end
        end
        m_trunc = nxt_trunc;
    endfunction

    function automatic obs_t model_expect(input logic rst, input logic [3:0] v, input logic [3:0] l);
        obs_t       e;
        logic [3:0] g;
        e = '0;
        if (rst) begin
            g        = model_gnt(v);
            e.gnt    = g;
            e.idx    = model_idx(g);
            e.vld    = |g;
            e.last   = |(g & l);
            e.locked = m_lock;
            e.trunc  = m_trunc;
        end
        return e;
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] l, input logic r);
        @(negedge clk);
        rst_n    = rst;
        req_vld  = v;
        req_last = l;
        out_rdy  = r;
        exp_q.push_back(model_expect(rst, v, l));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(req_vld, req_last, out_rdy);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = {gnt, gnt_idx, out_vld, out_last, locked, burst_trunc};
        return o;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic       rt [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] vt [4] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
        obs_t got, want;
        for (int c = 0; c < 4; c++) begin
            drive(rt[c], vt[c], 4'b1111, 1'b1);
            #1;
            got  = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reset[%0d]: got=%b want=%b (gnt,idx,vld,last,locked,trunc)", c, got, want);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        obs_t got, want;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 4'b1111, 4'b1111, 1'b1);
            #1;
            got  = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL round_robin[%0d]: got=%b want=%b", c, got, want);
            end
            tick();
        end
    endtask

    task automatic test_alternate();
        obs_t got, want;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 4'b0101, 4'b1111, 1'b1);
            #1;
            got  = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL alternate[%0d]: got=%b want=%b", c, got, want);
            end
            tick();
        end
    endtask

    task automatic test_burst_toggle();
        logic [3:0] vt [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1000};
        logic [3:0] lt [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b1000};
        logic       rt [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        obs_t got, want;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, vt[c], lt[c], rt[c]);
            #1;
            got  = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL burst_toggle[%0d]: got=%b want=%b", c, got, want);
            end
            tick();
        end
    endtask

    task automatic test_truncate();
        logic [3:0] vt [10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                                4'b1111, 4'b1111, 4'b1111, 4'b1111};
        logic [3:0] lt [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                4'b1111, 4'b1111, 4'b1111, 4'b1111};
        obs_t got, want;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, vt[c], lt[c], 1'b1);
            #1;
            got  = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL truncate[%0d]: got=%b want=%b", c, got, want);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_lock();
        logic       rt [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] vt [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b1111, 4'b1111};
        logic [3:0] lt [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
        obs_t got, want;
        for (int c = 0; c < 5; c++) begin
            drive(rt[c], vt[c], lt[c], 1'b1);
            #1;
            got  = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reset_mid_lock[%0d]: got=%b want=%b", c, got, want);
            end
            tick();
        end
    endtask

    task automatic test_owner_stall();
        logic [3:0] vt [6] = '{4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100};
        logic [3:0] lt [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0100};
        obs_t got, want;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, vt[c], lt[c], 1'b1);
            #1;
            got  = sample();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL owner_stall[%0d]: got=%b want=%b", c, got, want);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_alternate();
        test_burst_toggle();
        test_truncate();
        test_reset_mid_lock();
        test_owner_stall();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/arb_matrix_lru_ctrl.md
Name: arb_matrix_lru_ctrl

Overview:
Stateful least-recently-granted (LRG) matrix arbiter for WIDTH requesters sharing one downstream valid/ready channel. It holds the WIDTH x WIDTH priority matrix in flops and picks a winner combinationally from it. The grant is locked for multi-beat bursts until the burst's last beat. On burst completion the winner's priority is demoted, and a watchdog force-releases any burst that runs too long.

Parameters:
WIDTH, 4, number of requesters (>=2)
MAX_BURST, 16, max beats per locked burst before forced release (>=1)
IDX_W, $clog2(WIDTH), width of gnt_idx (derived, not overridable)
CNT_W, $clog2(MAX_BURST+1), width of the beat counter (derived)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active-low
req_vld  input  WIDTH  per-requester beat valid
req_last  input  WIDTH  per-requester last-beat flag, qualified by req_vld
out_rdy  input  1  downstream ready
out_vld  output  1  downstream valid, equals |gnt
out_last  output  1  req_last of granted requester
gnt  output  WIDTH  one-hot grant, zero when no winner
gnt_idx  output  IDX_W  binary index of gnt, 0 when gnt==0
locked  output  1  burst in progress, owner fixed
burst_trunc  output  1  one-cycle pulse when a burst is force-released by MAX_BURST

Behaviour:
- Matrix M[i][j] is stored only for i<j; M[j][i] is implied as ~M[i][j]. M[i][j]=1 means i beats j. Reset: all stored bits=1, so index 0 has highest priority and index WIDTH-1 lowest.
- Pick: win[i] = req_vld[i] AND, for all j!=i, (~req_vld[j] OR M[i][j]). The result is always one-hot or zero.
- States: IDLE, LOCK. State, owner, M and beat_cnt all reset on a clk edge with rst_n=0. All outputs are forced to 0 while rst_n=0.
- IDLE: gnt=win, combinational with zero-cycle latency. fire = out_vld & out_rdy.
  - fire & out_last -> stay IDLE, update M.
  - fire & ~out_last -> go LOCK, register owner=gnt_idx, beat_cnt=1.
  - If MAX_BURST==1, a non-last fire is treated as truncation: stay IDLE, update M, pulse burst_trunc.
- LOCK: gnt = onehot(owner) & req_vld[owner]. Other requesters are ignored. A deasserted req_vld[owner] stalls (gnt=0) but holds the lock.
  - fire & out_last -> IDLE, update M.
  - fire & ~out_last & beat_cnt==MAX_BURST-1 -> IDLE, update M, burst_trunc=1 for the next cycle.
  - Other fires increment beat_cnt.
- locked=1 in LOCK only.
- M update on completion with winner w, registered and visible from the next cycle: M[w][j]=0 and M[j][w]=1 for all j!=w. w becomes lowest priority; the relative order of the others is unchanged.
- out_vld does not depend on out_rdy, so there is no combinational out_rdy->gnt path. gnt may change between cycles in IDLE only if no fire occurred. Requesters must hold req_vld until granted.
- Simultaneous last-beat and new requests: the next winner is chosen from the updated M one cycle later. There are no back-to-back grants from stale M.
- Reset mid-burst: abort the burst and return to IDLE with reset M. No burst_trunc pulse.
- No requests: gnt=0, gnt_idx=0, M unchanged.

Decomposition:
- Package arb_pkg: state enum arb_state_e {ARB_IDLE, ARB_LOCK}, and function onehot2bin used for gnt_idx.
- Sub-module arb_matrix_pick: pure combinational pick (inputs req_vld and flattened upper-triangle M; output win). It is reusable by other arbiters.
- The controller contains the FSM, owner register, beat counter, M flops and the update logic.

Test Plan:
- WIDTH=4, after reset, req_vld=4'b1111, all last=1, out_rdy=1 for 4 cycles -> gnt 0001, 0010, 0100, 1000, each for 1 cycle. gnt is 0 on alternate cycles if the M-update bubble applies; the check is order 0,1,2,3.
- req_vld=4'b0101, last=1: grant 0, then next grant 2, then 0 again. LRG alternates between the two.
- Requester 1 sends a 3-beat burst with out_rdy toggling 1,0,1,0,1 while req 3 is also valid -> gnt stays 0010 for all 5 cycles, locked=1 until the third fire, then req 3 is granted.
- MAX_BURST=4, requester 2 never asserts last, out_rdy=1 -> after the 4th beat the FSM is IDLE, burst_trunc pulses once, and requester 2 becomes lowest priority.
- Mid-LOCK (owner=1, beat 2), drive rst_n=0 for 1 cycle -> all outputs 0 during reset. After reset locked=0, M is at reset value, and req 4'b1111 grants 0001.
- In LOCK, owner drops req_vld for 3 cycles -> out_vld=0 with no grant to others; owner resumes and completes the burst normally.
